// File: rtl/l2_port_arbiter_pkg.sv
// rtl/l2_port_arbiter_pkg.sv - shared types and line geometry for the L2 port arbiter
package l2_arb_types;

    localparam int L2_ADDR_WIDTH = 32;
    localparam int L2_LINE_WIDTH = 256;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } arb_state_t;

    typedef enum logic {
        REQ_I,
        REQ_D
    } requester_t;

    typedef struct packed {
        logic [L2_ADDR_WIDTH-1:0] address;
        logic                     read;
        logic                     write;
        logic [L2_LINE_WIDTH-1:0] wdata;
    } line_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - combinational two-way grant (I vs D), round-robin or fixed D priority
module rr_arbiter2
    import l2_arb_types::*;
#(
    parameter bit D_PRIORITY = 1'b0
) (
    input  logic [1:0] req,
    input  requester_t last_grant,
    output logic       grant_valid,
    output requester_t grant
);

    // req[0] is the I-cache, req[1] the D-cache
    always_comb begin
        grant_valid = |req;
        grant       = REQ_I;
        if (req == 2'b11) begin
            grant = (D_PRIORITY || last_grant == REQ_I) ? REQ_D : REQ_I;
        end else if (req[1]) begin
            grant = REQ_D;
        end
    end

endmodule

// File: rtl/l2_port_arbiter.sv
// rtl/l2_port_arbiter.sv - shares the L2 port between I-cache and D-cache, one line transaction at a time
module l2_port_arbiter
    import l2_arb_types::*;
#(
    parameter int ADDR_WIDTH = L2_ADDR_WIDTH,
    parameter int LINE_WIDTH = L2_LINE_WIDTH,
    parameter int D_PRIORITY = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] i_address,
    input  logic                  i_read,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp
);

    if (ADDR_WIDTH != L2_ADDR_WIDTH || LINE_WIDTH != L2_LINE_WIDTH) begin : g_bad_geometry
        $error("l2_port_arbiter widths must match l2_arb_types line geometry");
    end

    arb_state_t state;
    requester_t last_grant;
    line_req_t  req_q;
    line_req_t  i_line;
    line_req_t  d_line;
    logic       grant_valid;
    requester_t grant;

    rr_arbiter2 #(
        .D_PRIORITY(D_PRIORITY != 0)
    ) u_rr (
        .req        ({d_read | d_write, i_read}),
        .last_grant (last_grant),
        .grant_valid(grant_valid),
        .grant      (grant)
    );

    // A simultaneous D read and write is illegal; the write is taken
    always_comb begin
        i_line.address = i_address;
        i_line.read    = 1'b1;
        i_line.write   = 1'b0;
        i_line.wdata   = '0;
        d_line.address = d_address;
        d_line.read    = d_read & ~d_write;
        d_line.write   = d_write;
        d_line.wdata   = d_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= REQ_D;
            req_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        last_grant <= grant;
                        if (grant == REQ_D) begin
                            state <= SERVE_D;
                            req_q <= d_line;
                        end else begin
                            state <= SERVE_I;
                            req_q <= i_line;
                        end
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (mem_resp) begin
                        state       <= IDLE;
                        req_q.read  <= 1'b0;
                        req_q.write <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_address = req_q.address;
    assign mem_read    = req_q.read;
    assign mem_write   = req_q.write;
    assign mem_wdata   = req_q.wdata;

    assign i_resp  = (state == SERVE_I) && mem_resp;
    assign d_resp  = (state == SERVE_D) && mem_resp;
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

    a_no_resp_in_idle: assert property (@(posedge clk) disable iff (rst)
        !(state == IDLE && mem_resp));
    a_no_d_read_write: assert property (@(posedge clk) disable iff (rst)
        !(d_read && d_write));

endmodule

// File: tb/tb_l2_port_arbiter.sv
// tb/tb_l2_port_arbiter.sv - self-checking bench: round-robin DUT [0] and D-priority DUT [1]
module tb_l2_port_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  i_address [2];
    logic         i_read    [2];
    logic [255:0] i_rdata   [2];
    logic         i_resp    [2];
    logic [31:0]  d_address [2];
    logic         d_read    [2];
    logic         d_write   [2];
    logic [255:0] d_wdata   [2];
    logic [255:0] d_rdata   [2];
    logic         d_resp    [2];
    logic [31:0]  mem_address [2];
    logic         mem_read  [2];
    logic         mem_write [2];
    logic [255:0] mem_wdata [2];
    logic [255:0] mem_rdata [2];
    logic         mem_resp  [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        l2_port_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(256), .D_PRIORITY(g)) u_dut (
            .clk(clk), .rst(rst),
            .i_address(i_address[g]), .i_read(i_read[g]), .i_rdata(i_rdata[g]), .i_resp(i_resp[g]),
            .d_address(d_address[g]), .d_read(d_read[g]), .d_write(d_write[g]),
            .d_wdata(d_wdata[g]), .d_rdata(d_rdata[g]), .d_resp(d_resp[g]),
            .mem_address(mem_address[g]), .mem_read(mem_read[g]), .mem_write(mem_write[g]),
            .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]), .mem_resp(mem_resp[g])
        );
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        int           dut;
        logic         ir;
        logic         dr;
        logic         dw;
        logic [31:0]  ia;
        logic [31:0]  da;
        logic [255:0] wd;
        int           lat;
        logic [255:0] rd;
        logic         exp_d;
    } vec_t;

    vec_t tbl [11];

    function automatic vec_t mk(int dut, logic ir, logic dr, logic dw, logic [31:0] ia,
                                logic [31:0] da, logic [255:0] wd, int lat,
                                logic [255:0] rd, logic exp_d);
        vec_t v;
        v.dut = dut; v.ir = ir; v.dr = dr; v.dw = dw; v.ia = ia; v.da = da;
        v.wd = wd; v.lat = lat; v.rd = rd; v.exp_d = exp_d;
        return v;
    endfunction

    task automatic clear_inputs();
        for (int k = 0; k < 2; k++) begin
            i_read[k] = 0; i_address[k] = '0;
            d_read[k] = 0; d_write[k] = 0; d_address[k] = '0; d_wdata[k] = '0;
            mem_resp[k] = 0; mem_rdata[k] = '0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
    endtask

    // One transaction from IDLE: grant at N+1, response after v.lat wait cycles, then one idle cycle
    task automatic run_vec(input vec_t v);
        int k;
        logic [31:0] ea;
        logic ew;
        k = v.dut;
        ea = v.exp_d ? v.da : v.ia;
        ew = v.exp_d && v.dw;
        i_read[k] = v.ir; i_address[k] = v.ia;
        d_read[k] = v.dr; d_write[k] = v.dw; d_address[k] = v.da; d_wdata[k] = v.wd;
        @(posedge clk); #2;
        for (int c = 0; c <= v.lat; c++) begin
            chk("vec_read", mem_read[k], !ew);
            chk("vec_write", mem_write[k], ew);
            chk("vec_addr", mem_address[k], ea);
            if (ew) chk("vec_wdata", mem_wdata[k], v.wd);
            chk("vec_no_resp", {i_resp[k], d_resp[k]}, 2'b00);
            if (c < v.lat) begin
                @(posedge clk); #2;
            end
        end
        mem_resp[k] = 1'b1; mem_rdata[k] = v.rd;
        #1;
        chk("vec_i_resp", i_resp[k], !v.exp_d);
        chk("vec_d_resp", d_resp[k], v.exp_d);
        chk("vec_rdata", v.exp_d ? d_rdata[k] : i_rdata[k], v.rd);
        @(posedge clk); #1;
        clear_inputs();
        #1;
        chk("vec_idle_gap", {mem_read[k], mem_write[k], i_resp[k], d_resp[k]}, 4'b0000);
    endtask

    // Reference model state for the randomized engine
    bit busy [2], in_txn [2], drop_i [2], drop_d [2];
    int win [2], last [2], lat [2];
    int gl0 [$];
    int gl1 [$];

    task automatic run_engine(input int cycles, input int prob);
        gl0.delete(); gl1.delete();
        for (int k = 0; k < 2; k++) begin
            busy[k] = 0; in_txn[k] = 0; drop_i[k] = 0; drop_d[k] = 0; last[k] = 1; win[k] = 0;
        end
        for (int cyc = 0; cyc < cycles; cyc++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                if (drop_i[k]) begin
                    i_read[k] = 0; drop_i[k] = 0;
                end else if (!i_read[k] && $urandom_range(99) < prob) begin
                    i_read[k] = 1; i_address[k] = $urandom;
                end
                if (drop_d[k]) begin
                    d_read[k] = 0; d_write[k] = 0; drop_d[k] = 0;
                end else if (!(d_read[k] || d_write[k]) && $urandom_range(99) < prob) begin
                    d_write[k] = $urandom_range(1);
                    d_read[k] = !d_write[k];
                    d_address[k] = $urandom;
                    d_wdata[k] = {$urandom, $urandom, $urandom, $urandom,
                                  $urandom, $urandom, $urandom, $urandom};
                end
                mem_resp[k] = 0;
                if (mem_read[k] || mem_write[k]) begin
                    if (!in_txn[k]) begin
                        in_txn[k] = 1; lat[k] = $urandom_range(3);
                    end
                    if (lat[k] == 0) begin
                        mem_resp[k] = 1; in_txn[k] = 0;
                        mem_rdata[k] = {8{$urandom}};
                    end else begin
                        lat[k]--;
                    end
                end
            end
            #1;
            for (int k = 0; k < 2; k++) begin
                logic ew;
                ew = busy[k] && win[k] == 1 && d_write[k];
                chk("eng_active", mem_read[k] || mem_write[k], busy[k]);
                if (busy[k]) begin
                    chk("eng_addr", mem_address[k], win[k] == 1 ? d_address[k] : i_address[k]);
                    chk("eng_write", mem_write[k], ew);
                    chk("eng_read", mem_read[k], !ew);
                    if (ew) chk("eng_wdata", mem_wdata[k], d_wdata[k]);
                end
                chk("eng_i_resp", i_resp[k], busy[k] && win[k] == 0 && mem_resp[k]);
                chk("eng_d_resp", d_resp[k], busy[k] && win[k] == 1 && mem_resp[k]);
                if (mem_resp[k]) chk("eng_rdata", {i_rdata[k] ^ mem_rdata[k], d_rdata[k] ^ mem_rdata[k]} != 0, 1'b0);
                if (i_resp[k] || d_resp[k]) begin
                    if (k == 0) gl0.push_back(d_resp[k] ? 1 : 0);
                    else        gl1.push_back(d_resp[k] ? 1 : 0);
                end
                if (busy[k] && mem_resp[k]) begin
                    busy[k] = 0;
                    if (win[k] == 0) drop_i[k] = 1; else drop_d[k] = 1;
                end else if (!busy[k] && (i_read[k] || d_read[k] || d_write[k])) begin
                    if (i_read[k] && (d_read[k] || d_write[k]))
                        win[k] = (k == 1 || last[k] == 0) ? 1 : 0;
                    else
                        win[k] = i_read[k] ? 0 : 1;
                    last[k] = win[k];
                    busy[k] = 1;
                end
            end
        end
        clear_inputs();
    endtask

    initial begin
        tbl[0]  = mk(0, 1, 0, 0, 32'h0000_1040, 32'h0,         '0,              3, {32{8'hA5}}, 0);
        tbl[1]  = mk(0, 0, 0, 1, 32'h0,         32'h0000_2000, {16{16'h1234}}, 2, {32{8'h5A}}, 1);
        tbl[2]  = mk(0, 1, 1, 0, 32'h0000_3000, 32'h0000_4000, '0,              0, {32{8'hC3}}, 0);
        tbl[3]  = mk(0, 1, 1, 0, 32'h0000_3100, 32'h0000_4100, '0,              1, {32{8'h3C}}, 1);
        tbl[4]  = mk(0, 1, 0, 1, 32'h0000_3200, 32'h0000_4200, {16{16'hFEED}}, 2, {32{8'h11}}, 0);
        tbl[5]  = mk(0, 0, 1, 0, 32'h0,         32'h0000_5000, '0,              1, {32{8'h22}}, 1);
        tbl[6]  = mk(0, 1, 1, 0, 32'h0000_3300, 32'h0000_4300, '0,              0, {32{8'h33}}, 0);
        tbl[7]  = mk(1, 1, 1, 0, 32'h0000_6000, 32'h0000_7000, '0,              1, {32{8'h44}}, 1);
        tbl[8]  = mk(1, 1, 0, 1, 32'h0000_6100, 32'h0000_7100, {16{16'hBEEF}}, 0, {32{8'h55}}, 1);
        tbl[9]  = mk(1, 1, 0, 0, 32'h0000_6200, 32'h0,         '0,              2, {32{8'h66}}, 0);
        tbl[10] = mk(1, 1, 1, 0, 32'h0000_6300, 32'h0000_7300, '0,              1, {32{8'h77}}, 1);

        do_reset();
        for (int k = 0; k < 2; k++) begin
            mem_rdata[k] = {8{$urandom}};
            #1;
            chk("rst_mem_req", {mem_read[k], mem_write[k], i_resp[k], d_resp[k]}, 4'b0000);
            chk("rst_mem_addr", mem_address[k], 32'h0);
            chk("rst_mem_wdata", mem_wdata[k], '0);
            chk("rst_i_rdata", i_rdata[k], mem_rdata[k]);
            chk("rst_d_rdata", d_rdata[k], mem_rdata[k]);
        end
        clear_inputs();

        for (int r = 0; r < 11; r++) run_vec(tbl[r]);

        // D moves its address mid-flight; the latched address must hold
        d_read[0] = 1; d_address[0] = 32'h0000_6000;
        @(posedge clk); #2;
        chk("hold_grant", mem_read[0], 1'b1);
        d_address[0] = 32'h7777_0000;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #2;
            chk("hold_addr", mem_address[0], 32'h0000_6000);
        end
        mem_resp[0] = 1;
        #1 chk("hold_d_resp", {i_resp[0], d_resp[0]}, 2'b01);
        @(posedge clk); #1 clear_inputs();

        // Reset while SERVE_I is outstanding; first tie afterwards goes to I
        @(posedge clk); #1;
        i_read[0] = 1; i_address[0] = 32'h0000_8000;
        @(posedge clk); #2;
        chk("abort_grant", mem_read[0], 1'b1);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk("abort_drop", {mem_read[0], mem_write[0], i_resp[0]}, 3'b000);
        d_read[0] = 1; d_address[0] = 32'h0000_9000;
        @(posedge clk); #2;
        chk("abort_tie_i", {mem_read[0], mem_address[0]}, {1'b1, 32'h0000_8000});
        mem_resp[0] = 1;
        #1 chk("abort_i_resp", {i_resp[0], d_resp[0]}, 2'b10);
        @(posedge clk); #1 clear_inputs();

        // Continuous contention
        do_reset();
        run_engine(150, 100);
        chk("rr_count", gl0.size() >= 8, 1'b1);
        for (int j = 0; j < 8 && j < gl0.size(); j++) chk("rr_order", gl0[j], j % 2);
        chk("prio_first_d", gl1.size() > 0 ? gl1[0] : 99, 1);

        // Sparse random traffic
        do_reset();
        run_engine(600, 35);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/l2_port_arbiter.md
Name: l2_port_arbiter

Overview:
- Shares the single L2 cache port (which fronts the eviction write buffer and physical memory) between the L1 instruction cache and the L1 data cache.
- Grants one cache-line transaction at a time and latches the winner's request.
- Forwards the request downstream, then routes `mem_resp`/`mem_rdata` back to the winner only.
- Contention is resolved round-robin, or with fixed D priority, selected by parameter.

Parameters:
- `ADDR_WIDTH`, 32, address width.
- `LINE_WIDTH`, 256, cache line width in bits.
- `D_PRIORITY`, 0, 0 = round-robin on contention; 1 = D-cache always wins contention.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `i_address`  in  ADDR_WIDTH  I-cache line address.
- `i_read`  in  1  I-cache line read request.
- `i_rdata`  out  LINE_WIDTH  line returned to I-cache.
- `i_resp`  out  1  I-cache transaction done.
- `d_address`  in  ADDR_WIDTH  D-cache line address.
- `d_read`  in  1  D-cache line read request.
- `d_write`  in  1  D-cache line write (writeback) request.
- `d_wdata`  in  LINE_WIDTH  D-cache writeback line.
- `d_rdata`  out  LINE_WIDTH  line returned to D-cache.
- `d_resp`  out  1  D-cache transaction done.
- `mem_address`  out  ADDR_WIDTH  downstream (L2) address.
- `mem_read`  out  1  downstream read.
- `mem_write`  out  1  downstream write.
- `mem_wdata`  out  LINE_WIDTH  downstream write data.
- `mem_rdata`  in  LINE_WIDTH  downstream read data.
- `mem_resp`  in  1  downstream transaction done.

Behaviour:
- Protocol on all ports:
  - A requester holds its request and operands stable until it sees resp high.
  - It deasserts on the cycle after resp.
  - resp is a single-cycle pulse.
- FSM states: `IDLE`, `SERVE_I`, `SERVE_D`.
- `IDLE`:
  - No downstream request is asserted.
  - If only I requests → `SERVE_I`. If only D (read or write) requests → `SERVE_D`.
  - If both request: with `D_PRIORITY=1` → `SERVE_D`; otherwise grant the requester that is not `last_grant`.
  - On the grant edge, latch the winner's address, op (read/write) and wdata into `req_q`, and update `last_grant`.
- `SERVE_I` / `SERVE_D`:
  - `mem_address`, `mem_read`, `mem_write` and `mem_wdata` are driven from `req_q`.
  - When `mem_resp`=1, the winner's resp=1 in that same cycle and the winner's rdata = `mem_rdata` (combinational pass-through); next state is `IDLE`.
  - Loser resp stays 0 throughout.
- Latency:
  - Request seen in `IDLE` at cycle N gives `mem_read`/`mem_write` at N+1.
  - Requester resp appears in the same cycle as `mem_resp`.
  - One mandatory `IDLE` cycle follows between back-to-back transactions.
- `i_rdata`/`d_rdata` always equal `mem_rdata`; only the resp pulse qualifies the data.
- `d_read` and `d_write` asserted together is illegal: the write is taken, and a simulation assertion fires.
- Requests that arrive while a transaction is in flight wait. No request is dropped; the request is evaluated in the next `IDLE` cycle.
- Under continuous contention with `D_PRIORITY=0`, grants alternate strictly I, D, I, D….
- `mem_resp` in `IDLE` is ignored and a simulation assertion fires.
- Reset values:
  - State = `IDLE`; `last_grant` = D, so I wins the first tie; `req_q` = 0.
  - All outputs are 0 except the rdata outputs, which follow `mem_rdata`.
- Reset mid-transaction:
  - Return to `IDLE` on the next edge; the downstream request drops immediately.
  - No resp is issued for the aborted transaction; the requester re-requests.

Decomposition:
- Package `l2_arb_types`:
  - enum `arb_state_t` {`IDLE`, `SERVE_I`, `SERVE_D`}.
  - enum `requester_t` {`REQ_I`, `REQ_D`}.
  - struct `line_req_t` {address, read, write, wdata}.
- Sub-module `rr_arbiter2`: purely combinational 2-way grant logic from req[1:0], `last_grant` and `D_PRIORITY`. The FSM and the `last_grant` register stay in the top module.

Test Plan:
- I-only read of 0x0000_1040; `mem_resp` after 3 cycles with data 0xA5…A5 → `mem_read`=1 with `mem_address`=0x0000_1040 at N+1; `i_resp`=1 with `i_rdata`=0xA5…A5 in the `mem_resp` cycle; `d_resp` stays 0.
- D writeback of 0x0000_2000 with wdata 0x1234…; `mem_resp` after 2 cycles → `mem_write`=1 with `mem_wdata`=0x1234… held until `mem_resp`; `d_resp` pulses once.
- I and D both request every cycle for 8 transactions, `D_PRIORITY=0` → grant order I, D, I, D, I, D, I, D; exactly one resp per transaction.
- Same stimulus with `D_PRIORITY=1` → all D grants first; I is served only in an `IDLE` cycle with no D request.
- D changes `d_address` while `SERVE_D` is in flight → `mem_address` keeps the latched value.
- Assert `rst` during `SERVE_I` before `mem_resp` → `mem_read` is 0 the next cycle, no `i_resp`, state is `IDLE`, and the first post-reset tie goes to I.
